// File: rtl/i2c_deserializer_pkg.sv
// Shared constants for the I2C slave receive front end:
// FSM state encoding, default slave address and synchronizer depth.
package i2c_deserializer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_IGNORE    = 3'd7;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// Pin conditioning for SCL/SDA: synchronizer, history flop and
// detection of SCL edges plus START/STOP bus conditions.
module i2c_line_sync
    import i2c_deserializer_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_DEPTH-1:0] r_scl_sync;
    logic [SYNC_DEPTH-1:0] r_sda_sync;
    logic                  r_scl_hist;
    logic                  r_sda_hist;
    logic                  w_scl;
    logic                  w_sda;

    // Idle bus is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_DEPTH-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_DEPTH-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_DEPTH-1];
    assign w_sda = r_sda_sync[SYNC_DEPTH-1];

    assign o_sda      = w_sda;
    assign o_scl_rise = ~r_scl_hist & w_scl;
    assign o_scl_fall = r_scl_hist & ~w_scl;
    assign o_start    = w_scl & r_sda_hist & ~w_sda;
    assign o_stop     = w_scl & ~r_sda_hist & w_sda;

endmodule

// File: rtl/i2c_deserializer.sv
// I2C slave receive side: address decode, byte shifting and the
// ACK / byte handshakes for the serializer and register file.
module i2c_deserializer
    import i2c_deserializer_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       i2c_ack,
    output logic [7:0] i2c_wdata,
    output logic       i2c_xfc_write,
    output logic       i2c_xfc_read,
    output logic       i2c_rw,
    output logic       addr_match,
    output logic       start_out,
    output logic       stop_out
);

    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shift_next;
    logic       w_last_bit;

    logic [2:0] r_state;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_byte_done;
    logic       r_ack;
    logic [7:0] r_wdata;
    logic       r_xfc_write;
    logic       r_xfc_read;
    logic       r_rw;
    logic       r_addr_match;
    logic       r_start;
    logic       r_stop;

    i2c_line_sync u_line_sync (
        .i_clk      (Clock),
        .i_reset    (reset),
        .i_scl      (i2c_scl),
        .i_sda      (i2c_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_shift_next = {r_shift[6:0], w_sda};
    assign w_last_bit   = (r_bitcnt == 4'd7);

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= 4'd0;
            r_shift      <= 8'h00;
            r_byte_done  <= 1'b0;
            r_ack        <= 1'b0;
            r_wdata      <= 8'h00;
            r_xfc_write  <= 1'b0;
            r_xfc_read   <= 1'b0;
            r_rw         <= 1'b0;
            r_addr_match <= 1'b0;
            r_start      <= 1'b0;
            r_stop       <= 1'b0;
        end else begin
            r_xfc_write <= 1'b0;
            r_xfc_read  <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            // Bus conditions override any SCL edge seen in the same cycle.
            if (w_start) begin
                r_start      <= 1'b1;
                r_state      <= ST_ADDR;
                r_bitcnt     <= 4'd0;
                r_byte_done  <= 1'b0;
                r_ack        <= 1'b0;
                r_addr_match <= 1'b0;
            end else if (w_stop) begin
                r_stop       <= 1'b1;
                r_state      <= ST_IDLE;
                r_bitcnt     <= 4'd0;
                r_byte_done  <= 1'b0;
                r_ack        <= 1'b0;
                r_addr_match <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_next;
                            r_bitcnt <= w_last_bit ? 4'd0 : r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_rw <= w_sda;
                                if (r_shift[6:0] == SLAVE_ADDR)
                                    r_byte_done <= 1'b1;
                                else
                                    r_state <= ST_IGNORE;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done  <= 1'b0;
                            r_ack        <= 1'b1;
                            r_addr_match <= 1'b1;
                            r_xfc_read   <= r_rw;
                            r_state      <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_ack   <= 1'b0;
                            r_state <= r_rw ? ST_READ : ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_next;
                            r_bitcnt <= w_last_bit ? 4'd0 : r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_wdata     <= w_shift_next;
                                r_xfc_write <= 1'b1;
                                r_byte_done <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_ack       <= 1'b1;
                            r_state     <= ST_WRITE_ACK;
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            r_ack   <= 1'b0;
                            r_state <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= w_last_bit ? 4'd0 : r_bitcnt + 4'd1;
                            if (w_last_bit)
                                r_state <= ST_READ_ACK;
                        end
                    end
                    ST_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_xfc_read <= 1'b1;
                                r_state    <= ST_READ;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign i2c_ack       = r_ack;
    assign i2c_wdata     = r_wdata;
    assign i2c_xfc_write = r_xfc_write;
    assign i2c_xfc_read  = r_xfc_read;
    assign i2c_rw        = r_rw;
    assign addr_match    = r_addr_match;
    assign start_out     = r_start;
    assign stop_out      = r_stop;

endmodule

// File: tb/tb_i2c_deserializer.sv
// Bench for i2c_deserializer: a bit-banged I2C master with randomized
// bytes, checked against transaction-level expectations.
`timescale 1ns/1ps
module tb_i2c_deserializer;
    import i2c_deserializer_pkg::*;

    localparam int HALF = 16;
    localparam int Q    = 4;
    localparam logic [6:0] SLV = 7'h50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_pin;
    logic       ack, xw, xr, rw, am, st, sp;
    logic [7:0] wdata;

    int checks = 0;
    int failures = 0;
    int n_w = 0, n_r = 0, n_st = 0, n_sp = 0;
    logic [7:0] obs_w[$];
    logic [7:0] dat[8];

    // Open-drain bus: slave ACK pulls the line low.
    assign sda_pin = sda_m & ~ack;

    always #5 clk = ~clk;

    i2c_deserializer dut (
        .Clock         (clk),
        .reset         (reset),
        .i2c_scl       (scl_m),
        .i2c_sda       (sda_pin),
        .i2c_ack       (ack),
        .i2c_wdata     (wdata),
        .i2c_xfc_write (xw),
        .i2c_xfc_read  (xr),
        .i2c_rw        (rw),
        .addr_match    (am),
        .start_out     (st),
        .stop_out      (sp)
    );

    always @(negedge clk) begin
        if (xw) begin
            n_w++;
            obs_w.push_back(wdata);
        end
        if (xr) n_r++;
        if (st) n_st++;
        if (sp) n_sp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1;
            tick(Q);
            scl_m = 1'b1;
            tick(HALF);
        end else begin
            sda_m = 1'b1;
            tick(HALF);
        end
        sda_m = 1'b0;
        tick(HALF);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        tick(Q);
        sda_m = 1'b0;
        tick(HALF - Q);
        scl_m = 1'b1;
        tick(HALF);
        sda_m = 1'b1;
        tick(HALF);
    endtask

    task automatic send_bit(input logic b, output logic a_hi);
        tick(Q);
        sda_m = b;
        tick(HALF - Q);
        scl_m = 1'b1;
        tick(HALF / 2);
        a_hi = ack;
        tick(HALF / 2);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic b9,
                             output logic ack_d, output logic ack9);
        logic a;
        ack_d = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], a);
            ack_d |= a;
        end
        send_bit(b9, ack9);
    endtask

    // One full transaction; expectations come from the bus-level rules:
    // ACK only when addressed, one write strobe per written byte,
    // one read request at address ACK plus one per master ACK.
    task automatic xact(input string tag, input logic [6:0] a,
                        input logic r, input int n);
        int   bw, br, bst, bsp, bq, exp_w, exp_r;
        logic ad, a9, m;
        logic [7:0] got;
        m   = (a == SLV);
        bw  = n_w;
        br  = n_r;
        bst = n_st;
        bsp = n_sp;
        bq  = obs_w.size();
        bus_start();
        send_byte({a, r}, 1'b1, ad, a9);
        chk({tag, "_addr_ack"}, a9, m);
        chk({tag, "_addr_match"}, am, m);
        if (m) chk({tag, "_rw"}, rw, r);
        else chk({tag, "_ignore"}, dut.r_state, ST_IGNORE);
        for (int i = 0; i < n; i++) begin
            if (r) begin
                send_byte(dat[i], (i == n - 1), ad, a9);
                chk({tag, "_rd_noack"}, ad | a9, 0);
            end else begin
                send_byte(dat[i], 1'b1, ad, a9);
                chk({tag, "_wr_ack9"}, a9, m);
                chk({tag, "_wr_nodata_ack"}, ad, 0);
            end
        end
        bus_stop();
        exp_w = (m && !r) ? n : 0;
        exp_r = (m && r) ? n : 0;
        chk({tag, "_starts"}, n_st - bst, 1);
        chk({tag, "_stops"}, n_sp - bsp, 1);
        chk({tag, "_writes"}, n_w - bw, exp_w);
        chk({tag, "_reads"}, n_r - br, exp_r);
        for (int i = 0; i < exp_w; i++) begin
            got = (obs_w.size() > bq + i) ? obs_w[bq + i] : 8'hxx;
            chk({tag, "_wbyte"}, got, dat[i]);
        end
        chk({tag, "_end_match"}, am, 0);
        chk({tag, "_end_ack"}, ack, 0);
    endtask

    initial begin
        logic ad, a9, a;
        logic [7:0] keep;
        int bw, br, bst, bsp;

        reset = 1'b1;
        tick(3);
        chk("reset_outs", {ack, xw, xr, rw, am, st, sp, wdata}, 0);
        reset = 1'b0;
        tick(4);

        dat[0] = 8'hA5;
        xact("write", SLV, 1'b0, 1);
        chk("write_wdata", wdata, 8'hA5);

        for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
        xact("mismatch", 7'h51, 1'b0, 2);

        for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
        xact("read", SLV, 1'b1, 3);

        bw  = n_w;
        br  = n_r;
        bst = n_st;
        bus_start();
        send_byte(8'hA0, 1'b1, ad, a9);
        chk("rs_first_ack", a9, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), a);
        bus_start();
        send_byte(8'hA1, 1'b1, ad, a9);
        chk("rs_second_ack", a9, 1);
        chk("rs_rw", rw, 1);
        chk("rs_starts", n_st - bst, 2);
        send_byte(8'($urandom), 1'b1, ad, a9);
        bus_stop();
        chk("rs_no_write", n_w - bw, 0);
        chk("rs_reads", n_r - br, 1);

        keep = 8'($urandom);
        bw  = n_w;
        bsp = n_sp;
        bus_start();
        send_byte(8'hA0, 1'b1, ad, a9);
        send_byte(keep, 1'b1, ad, a9);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), a);
        bus_stop();
        chk("midstop_wdata", wdata, keep);
        chk("midstop_writes", n_w - bw, 1);
        chk("midstop_stops", n_sp - bsp, 1);
        chk("midstop_idle", dut.r_state, ST_IDLE);

        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 8'hA0 >> i, a);
        tick(Q);
        sda_m = 1'b1;
        tick(HALF - Q);
        scl_m = 1'b1;
        tick(HALF / 2);
        chk("rst_pre_ack", ack, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outs_mid", {ack, xw, xr, rw, am, st, sp, wdata}, 0);
        reset = 1'b0;
        tick(HALF / 2);
        scl_m = 1'b0;
        tick(HALF);
        chk("rst_stale_edge", {ack, am}, 0);
        chk("rst_idle", dut.r_state, ST_IDLE);
        for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
        xact("post_rst", SLV, 1'b0, 2);

        for (int t = 0; t < 6; t++) begin
            logic [6:0] ad7;
            ad7 = $urandom_range(0, 1) ? SLV : 7'($urandom);
            for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
            xact("rand", ad7, 1'($urandom), $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_deserializer.md
# i2c_deserializer

Receive-side front end of the I2C slave. Oversamples the raw `i2c_scl`/`i2c_sda` pins on the system clock, detects START/STOP, shifts in address and data bytes MSB-first, checks the 7-bit slave address, and drives the ACK request and byte handshakes that the transmit-side `Serializer` and the register file consume.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this slave answers to.
- `Clock`, in, 1: system clock. Must be at least 8x SCL.
- `reset`, in, 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `i2c_scl`, in, 1: raw SCL pin (asynchronous).
- `i2c_sda`, in, 1: raw SDA pin (asynchronous).
- `i2c_ack`, out, 1: level; high while the slave must pull SDA low for an ACK bit.
- `i2c_wdata`, out, 8: last received data byte; held until the next byte.
- `i2c_xfc_write`, out, 1: one-cycle pulse when a write data byte is complete.
- `i2c_xfc_read`, out, 1: one-cycle request for the next read byte, to the `Serializer` load strobe.
- `i2c_rw`, out, 1: R/W bit of the current address phase; 1 means read.
- `addr_match`, out, 1: high from address ACK until STOP or repeated START.
- `start_out`, out, 1: one-cycle pulse on START or repeated START.
- `stop_out`, out, 1: one-cycle pulse on STOP.

## Operation
- Input conditioning: 2-flop synchronizer plus a history flop per pin. Synchronizer and history flops reset to 1 (idle bus).
- Events, evaluated on the synchronized signals:
  - SCL rise: history 0, current 1.
  - SCL fall: history 1, current 0.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- START and STOP take priority over any SCL edge in the same cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
  - IDLE: leave on START.
  - ADDR: shift SDA in on each SCL rise. After 8 bits, compare bits [7:1] to `SLAVE_ADDR` and latch bit 0 into `i2c_rw`.
    - On match: on the next SCL fall, go to ADDR_ACK and raise `i2c_ack`.
    - On mismatch: go to IGNORE with no ACK.
  - ADDR_ACK: `i2c_ack` stays high until the 9th SCL fall, then drops.
    - `i2c_rw`=0 goes to WRITE.
    - `i2c_rw`=1 goes to READ. `i2c_xfc_read` pulses on the cycle `i2c_ack` rises, so the `Serializer` has data loaded before the ACK clock.
  - WRITE: shift in 8 bits on SCL rises. After the 8th rise:
    - Update `i2c_wdata` and pulse `i2c_xfc_write`.
    - On the next SCL fall, raise `i2c_ack` and go to WRITE_ACK. WRITE_ACK behaves like ADDR_ACK, then returns to WRITE.
  - READ: count 8 SCL rises; the `Serializer` drives SDA. Then go to READ_ACK.
  - READ_ACK: sample the master's ACK on the 9th SCL rise.
    - SDA=0: pulse `i2c_xfc_read` and return to READ.
    - SDA=1 (NACK): go to IGNORE.
  - IGNORE: wait for START or STOP.
- From any state:
  - START: pulse `start_out`, clear the bit counter, go to ADDR. This covers repeated START.
  - STOP: pulse `stop_out`, drop `i2c_ack` and `addr_match`, go to IDLE.
- Bit counter is 4 bits and resets to 0 at each byte boundary. A START/STOP mid-byte discards the partial byte, with no `i2c_xfc_write`.

## Timing
- Reset values: every output 0; FSM in IDLE.
- Pin to event: 3 `Clock` cycles (2 synchronizer + 1 edge compare).
- `i2c_xfc_write` fires 1 cycle after the 8th-bit SCL-rise event. `i2c_wdata` is valid in that same cycle.
- `i2c_ack` rises 1 cycle after the 8th SCL-fall event and falls 1 cycle after the 9th SCL-fall event.
- `i2c_xfc_read`:
  - First byte: same cycle `i2c_ack` rises in ADDR_ACK.
  - Later bytes: 1 cycle after the 9th SCL-rise event with ACK.
- START/STOP pulses fire 1 cycle after detection.
- Reset mid-transfer: IDLE next cycle. A stale SCL edge does not restart decoding; only a new START does.

## Structure
- Shared package holds:
  - FSM state encoding (3-bit localparams).
  - Default `SLAVE_ADDR`.
  - Synchronizer depth constant (2).
- Sub-module `i2c_line_sync`: synchronizer, history flops and START/STOP/edge detection for both pins. Instantiate it once.

## Test plan
- Write: START, 0xA0 (addr 0x50, W), ACK, 0xA5, ACK, STOP.
  - `i2c_ack` high for both 9th clocks.
  - `i2c_xfc_write` pulses once with `i2c_wdata`=0xA5.
  - `stop_out` pulses once.
- Address mismatch: START, 0xA2.
  - `i2c_ack` never rises; FSM reaches IGNORE.
  - Following bytes produce no `i2c_xfc_write`.
- Read: START, 0xA1, then master ACK, ACK, NACK.
  - `i2c_xfc_read` pulses 3 times: at address ACK and after each master ACK.
  - No pulse after the NACK.
- Repeated START: after 4 bits of a write data byte, issue START + 0xA1.
  - No `i2c_xfc_write`.
  - `start_out` pulses and `i2c_rw`=1.
- STOP mid-byte: STOP after 5 data bits.
  - `i2c_wdata` keeps its prior value; FSM returns to IDLE.
- Reset: assert `reset` while `i2c_ack`=1.
  - All outputs 0 next cycle.
  - A following full write transaction decodes normally.
